// File: rtl/store_buffer_if.sv
// Store, load-probe and BRAM port-B signals between the pipeline and the store buffer.
// The master side is the pipeline and the memory port; the slave side is the buffer.
interface store_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AWIDTH = 12
);
    logic                  st_valid;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [3:0]            st_web;
    logic [31:0]           st_dib;
    logic                  st_ready;

    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_conflict;

    logic                  mem_busy;
    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [MEM_AWIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;

    modport master (
        output st_valid, st_addr, st_web, st_dib, ld_valid, ld_addr, mem_busy,
        input  st_ready, ld_conflict, mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  st_valid, st_addr, st_web, st_dib, ld_valid, ld_addr, mem_busy,
        output st_ready, ld_conflict, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: queues byte-enabled stores, coalesces into the youngest entry, retires to BRAM port B.
// Latency: a store can retire the cycle after acceptance; port-B outputs are combinational from the head entry.
// Backpressure: st_ready drops only when full, not coalescing and not draining; loads hitting pending words raise ld_conflict.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AWIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    store_buffer_if.slave    sb,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WA = ADDR_WIDTH - 2;

    logic [WA-1:0] ent_addr [DEPTH];
    logic [3:0]    ent_web  [DEPTH];
    logic [31:0]   ent_data [DEPTH];

    logic [PW-1:0] head, tail, tail_m1;
    logic [CW-1:0] count;

    logic          drain, st_live, can_coalesce;
    logic          do_coalesce, do_push, do_pop;
    logic          ld_hit;
    logic [PW-1:0] offset;
    logic [WA-1:0] st_wa, ld_wa;
    logic          unused_low_bits;

    assign unused_low_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

    always_comb begin
        st_wa   = sb.st_addr[ADDR_WIDTH-1:2];
        ld_wa   = sb.ld_addr[ADDR_WIDTH-1:2];
        tail_m1 = tail - PW'(1);
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        // Reset blocks the retire so a reset cycle never leaves a half-done write.
        drain   = !empty && !sb.mem_busy && !rst;
        // The youngest entry is off limits once it is the one being popped.
        can_coalesce = !empty && (ent_addr[tail_m1] == st_wa) &&
                       !((count == CW'(1)) && drain);
        st_live      = sb.st_valid && (sb.st_web != 4'b0000);
        sb.st_ready  = (sb.st_web == 4'b0000) || can_coalesce || !full || drain;
        do_coalesce  = st_live && can_coalesce;
        do_push      = st_live && !can_coalesce && (!full || drain);
        do_pop       = drain;

        sb.mem_en   = drain;
        sb.mem_we   = drain ? ent_web[head] : 4'b0000;
        sb.mem_addr = drain ? ent_addr[head][MEM_AWIDTH-1:0] : '0;
        sb.mem_din  = drain ? ent_data[head] : 32'h0;
    end

    always_comb begin
        ld_hit = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head;
            if (({1'b0, offset} < count) && (ent_addr[i] == ld_wa)) begin
                ld_hit = 1'b1;
            end
        end
        sb.ld_conflict = sb.ld_valid && ld_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_web[i] <= 4'b0000;
            end
        end else begin
            if (do_pop) begin
                head <= head + PW'(1);
            end
            if (do_push) begin
                ent_addr[tail] <= st_wa;
                ent_web[tail]  <= sb.st_web;
                ent_data[tail] <= sb.st_dib;
                tail           <= tail + PW'(1);
            end
            if (do_coalesce) begin
                ent_web[tail_m1] <= ent_web[tail_m1] | sb.st_web;
                for (int b = 0; b < 4; b++) begin
                    if (sb.st_web[b]) begin
                        ent_data[tail_m1][8*b +: 8] <= sb.st_dib[8*b +: 8];
                    end
                end
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, retire, coalesce, fill/backpressure, load hazard, pop race, mid-op reset.
module tb_store_buffer;
    logic clk;
    logic rst;
    logic empty, full;
    int   checks;
    int   errors;

    store_buffer_if #(.ADDR_WIDTH(32), .MEM_AWIDTH(12)) sif ();

    store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .MEM_AWIDTH(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .sb    (sif.slave),
        .empty (empty),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        sif.st_valid = 1'b1;
        sif.st_addr  = a;
        sif.st_web   = w;
        sif.st_dib   = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sif.st_valid = 1'b0; sif.st_addr = '0; sif.st_web = '0; sif.st_dib = '0;
        sif.ld_valid = 1'b0; sif.ld_addr = '0; sif.mem_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", sif.st_ready, 1);
        chk("rst_mem_en", sif.mem_en, 0);
        chk("rst_mem_we", sif.mem_we, 0);
        chk("rst_mem_addr", sif.mem_addr, 0);
        chk("rst_mem_din", sif.mem_din, 0);
        chk("rst_conflict", sif.ld_conflict, 0);

        // single word store retires the next cycle
        store(32'h100, 4'hF, 32'hDEADBEEF);
        #1;
        chk("sw_no_early_en", sif.mem_en, 0);
        tick();
        sif.st_valid = 1'b0;
        #1;
        chk("sw_empty", empty, 0);
        chk("sw_en", sif.mem_en, 1);
        chk("sw_addr", sif.mem_addr, 12'h040);
        chk("sw_we", sif.mem_we, 4'hF);
        chk("sw_din", sif.mem_din, 32'hDEADBEEF);
        tick();
        chk("sw_drained", empty, 1);
        chk("sw_en_off", sif.mem_en, 0);

        // two byte stores to one word merge into a single write
        sif.mem_busy = 1'b1;
        store(32'h201, 4'b0010, 32'h0000AA00);
        tick();
        store(32'h203, 4'b1000, 32'hBB000000);
        #1;
        chk("co_ready", sif.st_ready, 1);
        tick();
        sif.st_valid = 1'b0;
        #1;
        chk("co_busy_en", sif.mem_en, 0);
        chk("co_pending", empty, 0);
        sif.mem_busy = 1'b0;
        #1;
        chk("co_en", sif.mem_en, 1);
        chk("co_we", sif.mem_we, 4'b1010);
        chk("co_din", sif.mem_din, 32'hBB00AA00);
        chk("co_addr", sif.mem_addr, 12'h080);
        tick();
        chk("co_single_write", empty, 1);

        // fill, backpressure, then enqueue while full and draining
        sif.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            store(32'(4 * i), 4'hF, 32'h1000 + 32'(i));
            tick();
        end
        sif.st_valid = 1'b0;
        #1;
        chk("fill_full", full, 1);
        store(32'h10, 4'hF, 32'h1004);
        #1;
        chk("fill_not_ready", sif.st_ready, 0);
        tick();
        chk("fill_still_full", full, 1);
        sif.mem_busy = 1'b0;
        #1;
        chk("fill_ready_drain", sif.st_ready, 1);
        chk("fill_en0", sif.mem_en, 1);
        chk("fill_addr0", sif.mem_addr, 12'h000);
        chk("fill_din0", sif.mem_din, 32'h1000);
        tick();
        sif.st_valid = 1'b0;
        #1;
        chk("fill_full_after_swap", full, 1);
        for (int k = 1; k <= 4; k++) begin
            chk("fill_order_en", sif.mem_en, 1);
            chk("fill_order_addr", sif.mem_addr, 64'(k));
            chk("fill_order_din", sif.mem_din, 64'(32'h1000 + k));
            tick();
        end
        chk("fill_empty", empty, 1);

        // load hazard against a pending word
        sif.mem_busy = 1'b1;
        store(32'h300, 4'hF, 32'h1);
        tick();
        sif.st_valid = 1'b0;
        sif.ld_valid = 1'b1;
        sif.ld_addr  = 32'h302;
        #1;
        chk("ld_hit", sif.ld_conflict, 1);
        sif.ld_addr = 32'h304;
        #1;
        chk("ld_miss", sif.ld_conflict, 0);
        sif.ld_addr  = 32'h302;
        sif.mem_busy = 1'b0;
        #1;
        chk("ld_hit_popping", sif.ld_conflict, 1);
        tick();
        chk("ld_after_retire", sif.ld_conflict, 0);
        sif.ld_valid = 1'b0;

        // a store to the word being popped must become a new entry
        sif.mem_busy = 1'b1;
        store(32'h400, 4'b0001, 32'h11);
        tick();
        sif.mem_busy = 1'b0;
        store(32'h401, 4'b0010, 32'h2200);
        #1;
        chk("race_ready", sif.st_ready, 1);
        chk("race_we0", sif.mem_we, 4'b0001);
        chk("race_din0", sif.mem_din, 32'h11);
        tick();
        sif.st_valid = 1'b0;
        #1;
        chk("race_pending", empty, 0);
        chk("race_en1", sif.mem_en, 1);
        chk("race_we1", sif.mem_we, 4'b0010);
        chk("race_din1", sif.mem_din, 32'h2200);
        chk("race_addr1", sif.mem_addr, 12'h100);
        tick();
        chk("race_empty", empty, 1);

        // reset with pending stores discards them without a write
        sif.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            store(32'h500 + 32'(4 * i), 4'hF, 32'(i));
            tick();
        end
        sif.st_valid = 1'b0;
        #1;
        chk("mr_pending", empty, 0);
        rst = 1'b1;
        sif.mem_busy = 1'b0;
        #1;
        chk("mr_en_during", sif.mem_en, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_empty", empty, 1);
        chk("mr_en_after", sif.mem_en, 0);
        store(32'h600, 4'b0000, 32'hFFFFFFFF);
        #1;
        chk("zero_ready", sif.st_ready, 1);
        tick();
        sif.st_valid = 1'b0;
        #1;
        chk("zero_empty", empty, 1);
        chk("zero_en", sif.mem_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
